sll_seq_shifter: RTL and testbench

SLL_SEQ_SHIFTER -- requirements
Module: sll_seq_shifter

---
 rtl/sll_seq_shifter_if.sv | 20 ++
 rtl/sll_seq_shifter.sv | 83 ++++++++
 tb/tb_sll_seq_shifter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sll_seq_shifter_if.sv
// rtl/sll_seq_shifter_if.sv - request/result signal bundle for the sequential shift-left-logical unit
interface sll_seq_shifter_if;
   logic        start;
   logic [5:0]  Signal;
   logic [31:0] dataA;
   logic [4:0]  dataB;
   logic        busy;
   logic        done;
   logic [31:0] dataOut;

   modport master (
      output start, Signal, dataA, dataB,
      input  busy, done, dataOut
   );

   modport slave (
      input  start, Signal, dataA, dataB,
      output busy, done, dataOut
   );
endinterface

// File: rtl/sll_seq_shifter.sv
// rtl/sll_seq_shifter.sv - five-stage logarithmic shift-left-logical unit with fixed latency
module sll_seq_shifter #(
   parameter logic [5:0] SLL = 6'b000000
) (
   input  logic             clk,
   input  logic             reset,
   sll_seq_shifter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_acc;
   logic [4:0]  r_amt;
   logic [2:0]  r_k;
   logic [31:0] r_dout;
   logic        w_accept;
   logic        w_load;
   logic [31:0] w_stage;

   assign w_accept = bus.start && (bus.Signal == SLL);
   assign w_load   = w_accept && ((r_state == IDLE) || (r_state == DONE));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = SHIFT;
         SHIFT:   if (r_k == 3'd4) w_state_nxt = DONE;
         DONE:    w_state_nxt = w_accept ? SHIFT : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Stage k shifts by 2^k when bit k of the amount is set; five stages cover 0..31.
   always_comb begin
      w_stage = r_acc;
      case (r_k)
         3'd0:    if (r_amt[0]) w_stage = r_acc << 1;
         3'd1:    if (r_amt[1]) w_stage = r_acc << 2;
         3'd2:    if (r_amt[2]) w_stage = r_acc << 4;
         3'd3:    if (r_amt[3]) w_stage = r_acc << 8;
         3'd4:    if (r_amt[4]) w_stage = r_acc << 16;
         default: w_stage = r_acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc  <= 32'h0;
         r_amt  <= 5'd0;
         r_k    <= 3'd0;
         r_dout <= 32'h0;
      end else if (w_load) begin
         r_acc <= bus.dataA;
         r_amt <= bus.dataB;
         r_k   <= 3'd0;
      end else if (r_state == SHIFT) begin
         r_acc <= w_stage;
         r_k   <= r_k + 3'd1;
         if (r_k == 3'd4) begin
            r_dout <= w_stage;
         end
      end
   end

   assign bus.busy    = (r_state == SHIFT);
   assign bus.done    = (r_state == DONE);
   assign bus.dataOut = r_dout;

endmodule

// File: tb/tb_sll_seq_shifter.sv
// tb/tb_sll_seq_shifter.sv - directed and randomised checks of sll_seq_shifter
module tb_sll_seq_shifter;

   localparam logic [5:0] SLL = 6'b000000;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] last_out;

   sll_seq_shifter_if bus ();

   sll_seq_shifter #(.SLL(SLL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one operation and leaves the bench in the DONE cycle.
   task automatic do_op(input logic [31:0] a, input logic [4:0] b, input bit disturb);
      logic [31:0] exp;
      exp = a << b;
      bus.start  = 1'b1;
      bus.Signal = SLL;
      bus.dataA  = a;
      bus.dataB  = b;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("busy_phase_busy", {31'b0, bus.busy}, 32'd1);
         chk("busy_phase_done", {31'b0, bus.done}, 32'd0);
         chk("busy_phase_hold", bus.dataOut, last_out);
         if (disturb && i == 1) begin
            bus.start = 1'b1;
            bus.dataA = ~a;
            bus.dataB = b + 5'd3;
         end else if (disturb && i == 2) begin
            bus.start  = 1'b0;
            bus.Signal = 6'b000010;
            bus.dataA  = 32'hDEAD_BEEF;
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      chk("done_pulse", {31'b0, bus.done}, 32'd1);
      chk("done_busy", {31'b0, bus.busy}, 32'd0);
      chk("result", bus.dataOut, exp);
      last_out = exp;
      bus.Signal = SLL;
   endtask

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.Signal = SLL;
      bus.dataA  = 32'h0;
      bus.dataB  = 5'd0;
      last_out   = 32'h0;
      tick();
      tick();
      chk("reset_busy", {31'b0, bus.busy}, 32'd0);
      chk("reset_done", {31'b0, bus.done}, 32'd0);
      chk("reset_out", bus.dataOut, 32'h0);
      reset = 1'b0;

      do_op(32'h0000_0001, 5'd4, 1'b0);
      chk("basic_val", bus.dataOut, 32'h0000_0010);
      tick();
      chk("basic_done_drop", {31'b0, bus.done}, 32'd0);

      do_op(32'h8000_0001, 5'd0, 1'b0);
      chk("amt0_val", bus.dataOut, 32'h8000_0001);
      tick();
      do_op(32'hFFFF_FFFF, 5'd31, 1'b0);
      chk("amt31_val", bus.dataOut, 32'h8000_0000);
      tick();

      do_op(32'h0000_0003, 5'd2, 1'b1);
      chk("ignored_val", bus.dataOut, 32'h0000_000C);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("single_done", {31'b0, bus.done}, 32'd0);
         chk("no_restart", {31'b0, bus.busy}, 32'd0);
      end

      bus.start  = 1'b1;
      bus.Signal = 6'b000010;
      bus.dataA  = 32'h1234_5678;
      bus.dataB  = 5'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("badsig_busy", {31'b0, bus.busy}, 32'd0);
         chk("badsig_done", {31'b0, bus.done}, 32'd0);
         chk("badsig_out", bus.dataOut, 32'h0000_000C);
      end
      bus.start  = 1'b0;
      bus.Signal = SLL;

      bus.start = 1'b1;
      bus.dataA = 32'h0000_0001;
      bus.dataB = 5'd4;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset_busy", {31'b0, bus.busy}, 32'd0);
      chk("midreset_done", {31'b0, bus.done}, 32'd0);
      chk("midreset_out", bus.dataOut, 32'h0);
      last_out = 32'h0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("midreset_no_done", {31'b0, bus.done}, 32'd0);
      end

      reset      = 1'b1;
      bus.start  = 1'b1;
      bus.dataA  = 32'h0000_00FF;
      bus.dataB  = 5'd1;
      tick();
      chk("reset_priority", {31'b0, bus.busy}, 32'd0);
      reset     = 1'b0;
      bus.start = 1'b0;
      tick();

      do_op(32'h0000_0005, 5'd1, 1'b0);
      chk("b2b_first", bus.dataOut, 32'h0000_000A);
      do_op(32'h0000_0007, 5'd3, 1'b0);
      chk("b2b_second", bus.dataOut, 32'h0000_0038);
      tick();
      chk("b2b_idle", {31'b0, bus.done}, 32'd0);

      for (int n = 0; n < 1000; n++) begin
         do_op($urandom, 5'($urandom_range(0, 31)), 1'b0);
      end
      tick();
      chk("final_idle_busy", {31'b0, bus.busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
